// File: rtl/hex_scan_display.sv
// Time-multiplexed driver for DIGITS common-anode 7-segment digits with prescaled scan, dead time,
// per-digit dp/blank and frame-synchronous commit. Define HEX_SCAN_LZS_EN for leading-zero suppression.
module hex_scan_display #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYC      = 2,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_done
);

  localparam int PC_W  = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW != 0}};

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h98;
      4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hA7;  4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
    endcase
  endfunction

  logic [PC_W-1:0]     pc_q, pc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] stg_data_q, stg_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   stg_blank_q, stg_blank_d, disp_blank_q, disp_blank_d;
  logic                pend_q, pend_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                fd_q, fd_d;
  logic [DIGITS-1:0]   supp;
  logic [DIGITS-1:0]   sel;
  logic [3:0]          cur_nib;
  logic                slot_end, boundary;

`ifdef HEX_SCAN_LZS_EN
  // Walk down from the leftmost digit; stop suppressing at the first significant one.
  always_comb begin
    logic lead;
    supp = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && disp_data_q[4*i +: 4] == 4'h0 && !disp_dp_q[i]) supp[i] = 1'b1;
      else                                                        lead    = 1'b0;
    end
  end
`else
  assign supp = '0;
`endif

  always_comb begin
    // NOTE: every _d gets a default before any branch so no latch is inferred.
    pc_d         = pc_q;
    idx_d        = idx_q;
    stg_data_d   = stg_data_q;
    stg_dp_d     = stg_dp_q;
    stg_blank_d  = stg_blank_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_d       = pend_q;
    seg_d        = 8'hFF;
    dig_d        = DIG_OFF;

    slot_end = (pc_q == PC_LAST);
    boundary = en && slot_end && (idx_q == IDX_LAST);
    fd_d     = boundary;
    cur_nib  = disp_data_q[4*int'(idx_q) +: 4];
    for (int i = 0; i < DIGITS; i++) sel[i] = (int'(idx_q) == i);

    if (!en) begin
      // Dark and idle: the display follows staging so re-enable shows the latest value.
      pc_d         = '0;
      idx_d        = '0;
      disp_data_d  = stg_data_q;
      disp_dp_d    = stg_dp_q;
      disp_blank_d = stg_blank_q;
      pend_d       = 1'b0;
    end else begin
      pc_d = slot_end ? '0 : pc_q + PC_W'(1);
      if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      if (boundary && pend_q) begin
        disp_data_d  = stg_data_q;
        disp_dp_d    = stg_dp_q;
        disp_blank_d = stg_blank_q;
        pend_d       = 1'b0;
      end
      if (int'(pc_q) >= BLANK_CYC) begin
        dig_d = DIG_OFF ^ sel;
        if (!disp_blank_q[idx_q] && !supp[idx_q]) begin
          seg_d    = hex_seg(cur_nib);
          seg_d[7] = ~disp_dp_q[idx_q];
        end
      end
    end

    // A load on a boundary cycle stays pending: the commit above took the old staging.
    if (load) begin
      stg_data_d  = data;
      stg_dp_d    = dp;
      stg_blank_d = blank;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= '0;
      idx_q        <= '0;
      stg_data_q   <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_q       <= 1'b0;
      seg_q        <= 8'hFF;
      dig_q        <= DIG_OFF;
      fd_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pc_q         <= pc_d;
      idx_q        <= idx_d;
      stg_data_q   <= stg_data_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_q       <= pend_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      fd_q         <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: a cycle-count reference model queues the expected outputs,
// a monitor pops and compares them one cycle later.
module tb_hex_scan_display;

  localparam int DIGITS = 4, CLK_DIV = 4, BLANK_CYC = 1, DIG_ACTIVE_LOW = 1;
  localparam logic [7:0] SEG_TBL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0, blank = '0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  hex_scan_display #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC),
                     .DIG_ACTIVE_LOW(DIG_ACTIVE_LOW)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp(dp), .blank(blank),
    .seg(seg), .dig(dig), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] seg; logic [3:0] dig; logic fd; } exp_t;
  exp_t sb_q[$];
  int n_checks = 0, n_err = 0;

  // Reference model: scan position derived from the number of enabled cycles.
  int          m_n = 0;
  logic [15:0] m_stg_data = '0, m_disp_data = '0;
  logic [3:0]  m_stg_dp = '0, m_disp_dp = '0, m_stg_blank = '0, m_disp_blank = '0;
  logic        m_pend = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int i);
    logic [7:0] s;
    logic [3:0] nib;
    int top;
    nib = m_disp_data[4*i +: 4];
    if (m_disp_blank[i]) return 8'hFF;
`ifdef HEX_SCAN_LZS_EN
    top = 0;
    for (int j = 0; j < DIGITS; j++)
      if (m_disp_data[4*j +: 4] != 4'h0 || m_disp_dp[j]) top = j;
    if (i > top) return 8'hFF;
`else
    top = DIGITS;
`endif
    s = SEG_TBL[nib];
    if (m_disp_dp[i]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic step(input logic r, input logic e, input logic ld, input logic [15:0] d,
                      input logic [3:0] p, input logic [3:0] b);
    exp_t x;
    int pc, idx;
    logic [3:0] oh;
    @(negedge clk);
    rst = r; en = e; load = ld; data = d; dp = p; blank = b;
    x.seg = 8'hFF; x.dig = 4'hF; x.fd = 1'b0;
    if (r) begin
      m_n = 0; m_pend = 1'b0;
      m_stg_data = '0; m_stg_dp = '0; m_stg_blank = '0;
      m_disp_data = '0; m_disp_dp = '0; m_disp_blank = '0;
    end else begin
      if (e) begin
        pc  = m_n % CLK_DIV;
        idx = (m_n / CLK_DIV) % DIGITS;
        x.fd = (pc == CLK_DIV - 1) && (idx == DIGITS - 1);
        if (pc >= BLANK_CYC) begin
          oh = 4'b0001 << idx;
          x.dig = ~oh;
          x.seg = exp_seg(idx);
        end
        if (x.fd && m_pend) begin
          m_disp_data = m_stg_data; m_disp_dp = m_stg_dp; m_disp_blank = m_stg_blank;
          m_pend = 1'b0;
        end
        m_n++;
      end else begin
        m_disp_data = m_stg_data; m_disp_dp = m_stg_dp; m_disp_blank = m_stg_blank;
        m_pend = 1'b0;
        m_n = 0;
      end
      if (ld) begin
        m_stg_data = d; m_stg_dp = p; m_stg_blank = b;
        m_pend = 1'b1;
      end
    end
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic ld_run(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input int n);
    step(1'b0, 1'b1, 1'b1, d, p, b);
    idle(n);
  endtask

  // Monitor: one registered output per cycle, compared well after the edge.
  always @(posedge clk) begin
    exp_t x;
    #2;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("seg", seg, x.seg);
      check("dig", {4'h0, dig}, {4'h0, x.dig});
      check("frame_done", {7'h0, frame_done}, {7'h0, x.fd});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    // Basic scan with the committed value appearing after the first boundary.
    step(1'b0, 1'b1, 1'b1, 16'h12AF, 4'h0, 4'h0);
    idle(40);
    // Two mid-frame loads; only the later one reaches the display.
    step(1'b0, 1'b1, 1'b1, 16'h0005, 4'h0, 4'h0);
    idle(1);
    ld_run(16'h0009, 4'h0, 4'h0, 36);
    // Decimal point on digit 2, blank on digit 0.
    ld_run(16'h8888, 4'b0100, 4'b0001, 40);
    // Drop enable mid-slot, then restart from digit 0.
    idle(5);
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(20);
    // Asynchronous reset away from any clock edge.
    idle(2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_seg", seg, 8'hFF);
    check("async_rst_dig", {4'h0, dig}, 8'h0F);
    repeat (2) step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(20);
    // Leading-zero patterns (suppressed only when the feature is compiled in).
    ld_run(16'h0030, 4'h0, 4'h0, 40);
    ld_run(16'h0000, 4'h0, 4'h0, 40);
    ld_run(16'h0000, 4'b0100, 4'h0, 40);
    // Randomised enable, loads and contents.
    for (int i = 0; i < 800; i++) begin
      logic e, ld;
      logic [3:0] b;
      e  = ($urandom_range(0, 24) != 0);
      ld = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(1'b0, e, ld, 16'($urandom), 4'($urandom), b);
    end
    idle(2);
    repeat (2) @(posedge clk);
    #4;
    check("scoreboard_drained", 8'(sb_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
